// File: rtl/twi_pkg.sv
// Shared constants and state encoding for the TWI register-bank controller
// and other command sinks on the TWI slave byte interface.
package twi_pkg;

  localparam int unsigned TWI_BYTE_W   = 8;
  localparam logic [7:0]  TWI_BAD_READ = 8'hFF;

  typedef enum logic [1:0] {
    TWI_RC_IDLE    = 2'd0,
    TWI_RC_GET_PTR = 2'd1,
    TWI_RC_DATA    = 2'd2
  } twiRcState_t;

endpackage

// File: rtl/twi_wdt.sv
// Saturating command watchdog: counts clk cycles since the last clear and
// pulses expire on the cycle the count reaches WDT_CYCLES (0 disables).
module twi_wdt #(
  parameter logic [23:0] WDT_CYCLES = 24'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expire
);

  logic [23:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != WDT_CYCLES) begin
      cnt <= cnt + 24'd1;
    end
  end

  // Fires once, on the increment into saturation; a clear in the same cycle wins.
  assign expire = (WDT_CYCLES != 24'd0) && !clr && (cnt == WDT_CYCLES - 24'd1);

endmodule

// File: rtl/twi_reg_ctrl.sv
// Register-bank controller behind the TWI slave byte interface: pointer byte,
// auto-incrementing writes/reads, read-only status window and command watchdog.
module twi_reg_ctrl
  import twi_pkg::*;
#(
  parameter int unsigned NREGS      = 8,
  parameter int unsigned RO_BASE    = 4,
  parameter logic [23:0] WDT_CYCLES = 24'd1000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           xfer_start,
  input  logic                           xfer_stop,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  input  logic                           tx_req,
  output logic [7:0]                     tx_data,
  output logic [8*RO_BASE-1:0]           regs_out,
  input  logic [8*(NREGS-RO_BASE)-1:0]   status_in,
  output logic [RO_BASE-1:0]             wr_strobe,
  output logic                           wdt_expired
);

  localparam int unsigned PW = (NREGS > 1) ? $clog2(NREGS) : 1;

  twiRcState_t          state, stateNext;
  logic [PW-1:0]        ptr;
  logic                 ptrBad;
  logic [8*RO_BASE-1:0] regsQ;
  logic [RO_BASE-1:0]   wrStrobeQ;
  logic [7:0]           txDataQ;
  logic                 wdtExpQ;
  logic [7:0]           ptrByte;
  logic                 rxAct, txAct, ptrLoad, wrAccept, ptrInc, wdtExpire;
  logic [7:0]           rdByte;

  assign ptrByte = 8'(ptr);

  // START/STOP take the cycle: a byte or tx_req coinciding with them is not processed.
  always_comb begin
    stateNext = state;
    rxAct     = 1'b0;
    txAct     = 1'b0;
    if (xfer_start) begin
      stateNext = TWI_RC_GET_PTR;
    end else if (xfer_stop) begin
      stateNext = TWI_RC_IDLE;
    end else if (state != TWI_RC_IDLE) begin
      rxAct = rx_valid;
      txAct = tx_req && !rx_valid;
      if (rx_valid && state == TWI_RC_GET_PTR) stateNext = TWI_RC_DATA;
    end
    ptrLoad  = rxAct && (state == TWI_RC_GET_PTR);
    wrAccept = rxAct && (state == TWI_RC_DATA) && !ptrBad && (ptrByte < 8'(RO_BASE));
    ptrInc   = (rxAct && (state == TWI_RC_DATA)) || txAct;
  end

  always_comb begin
    rdByte = TWI_BAD_READ;
    if (!ptrBad) begin
      for (int unsigned i = 0; i < RO_BASE; i++) begin
        if (ptrByte == 8'(i)) rdByte = regsQ[8*i +: 8];
      end
      for (int unsigned i = RO_BASE; i < NREGS; i++) begin
        if (ptrByte == 8'(i)) rdByte = status_in[8*(i-RO_BASE) +: 8];
      end
    end
  end

  twi_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) uWdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (wrAccept),
    .expire (wdtExpire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TWI_RC_IDLE;
      ptr       <= '0;
      ptrBad    <= 1'b0;
      regsQ     <= '0;
      wrStrobeQ <= '0;
      txDataQ   <= '0;
      wdtExpQ   <= 1'b0;
    end else begin
      state     <= stateNext;
      wrStrobeQ <= '0;
      txDataQ   <= rdByte;
      if (ptrLoad) begin
        // Full-width compare so out-of-range pointers are flagged, never aliased.
        if (rx_data < 8'(NREGS)) begin
          ptr    <= rx_data[PW-1:0];
          ptrBad <= 1'b0;
        end else begin
          ptrBad <= 1'b1;
        end
      end else if (ptrInc) begin
        ptr <= ptr + PW'(1);
      end
      if (wrAccept) begin
        for (int unsigned i = 0; i < RO_BASE; i++) begin
          if (ptrByte == 8'(i)) begin
            regsQ[8*i +: 8] <= rx_data;
            wrStrobeQ[i]    <= 1'b1;
          end
        end
        wdtExpQ <= 1'b0;
      end else if (wdtExpire) begin
        regsQ   <= '0;
        wdtExpQ <= 1'b1;
      end
    end
  end

  assign tx_data     = txDataQ;
  assign regs_out    = regsQ;
  assign wr_strobe   = wrStrobeQ;
  assign wdt_expired = wdtExpQ;

endmodule

// File: tb/tb_twi_reg_ctrl.sv
// Directed testbench for twi_reg_ctrl (NREGS=8, RO_BASE=4, WDT_CYCLES=16).
module tb_twi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        xfer_start = 1'b0;
  logic        xfer_stop = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_data;
  logic [31:0] regs_out;
  logic [31:0] status_in = '0;
  logic [3:0]  wr_strobe;
  logic        wdt_expired;

  int nTests = 0;
  int nFail  = 0;

  twi_reg_ctrl #(
    .NREGS(8),
    .RO_BASE(4),
    .WDT_CYCLES(24'd16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .xfer_start  (xfer_start),
    .xfer_stop   (xfer_stop),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .regs_out    (regs_out),
    .status_in   (status_in),
    .wr_strobe   (wr_strobe),
    .wdt_expired (wdt_expired)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: each drives a one-cycle pulse and returns at the negedge
  // following the capturing posedge.
  task automatic doReset();
    @(negedge clk) rst = 1'b1;
    xfer_start = 1'b0; xfer_stop = 1'b0; rx_valid = 1'b0; tx_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk) xfer_start = 1'b1;
    @(negedge clk) xfer_start = 1'b0;
  endtask

  task automatic pulseStop();
    @(negedge clk) xfer_stop = 1'b1;
    @(negedge clk) xfer_stop = 1'b0;
  endtask

  task automatic pulseStartStop();
    @(negedge clk) begin xfer_start = 1'b1; xfer_stop = 1'b1; end
    @(negedge clk) begin xfer_start = 1'b0; xfer_stop = 1'b0; end
  endtask

  task automatic pulseRx(input logic [7:0] b);
    @(negedge clk) begin rx_data = b; rx_valid = 1'b1; end
    @(negedge clk) rx_valid = 1'b0;
  endtask

  task automatic pulseTx();
    @(negedge clk) tx_req = 1'b1;
    @(negedge clk) tx_req = 1'b0;
  endtask

  task automatic pulseRxTx(input logic [7:0] b);
    @(negedge clk) begin rx_data = b; rx_valid = 1'b1; tx_req = 1'b1; end
    @(negedge clk) begin rx_valid = 1'b0; tx_req = 1'b0; end
  endtask

  task automatic test_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    nTests++;
    if ({tx_data, regs_out, wr_strobe, wdt_expired} !== 45'd0) begin
      nFail++;
      $display("FAIL reset_outputs: tx=%h regs=%h strobe=%b wdt=%b, want all 0",
               tx_data, regs_out, wr_strobe, wdt_expired);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_write();
    doReset();
    status_in = 32'h0000_00C4;
    pulseStart();
    pulseRx(8'h01);
    pulseRx(8'hAA);
    nTests++;
    if (regs_out[15:8] !== 8'hAA || wr_strobe !== 4'b0010) begin
      nFail++;
      $display("FAIL basic_wr1: reg1=%h strobe=%b, want aa 0010", regs_out[15:8], wr_strobe);
    end
    pulseRx(8'h55);
    nTests++;
    if (regs_out[23:16] !== 8'h55 || wr_strobe !== 4'b0100) begin
      nFail++;
      $display("FAIL basic_wr2: reg2=%h strobe=%b, want 55 0100", regs_out[23:16], wr_strobe);
    end
    pulseStop();
    nTests++;
    if (wr_strobe !== 4'b0000 || regs_out !== 32'h0055_AA00) begin
      nFail++;
      $display("FAIL basic_after: strobe=%b regs=%h, want 0000 0055aa00", wr_strobe, regs_out);
    end
    // ptr should be 3; restart keeps it, one tx_req moves it to 4 (status 0xC4).
    pulseStart();
    pulseTx();
    @(negedge clk);
    nTests++;
    if (tx_data !== 8'hC4) begin
      nFail++;
      $display("FAIL basic_ptr3: tx_data=%h, want c4", tx_data);
    end
  endtask

  task automatic test_combined_read();
    doReset();
    status_in = 32'h0000_7E3C;
    pulseStart();
    pulseRx(8'h04);
    pulseStart();
    @(negedge clk);
    nTests++;
    if (tx_data !== 8'h3C) begin
      nFail++;
      $display("FAIL read_first: tx_data=%h, want 3c", tx_data);
    end
    pulseTx();
    @(negedge clk);
    nTests++;
    if (tx_data !== 8'h7E) begin
      nFail++;
      $display("FAIL read_next: tx_data=%h, want 7e", tx_data);
    end
  endtask

  task automatic test_ro_wrap();
    doReset();
    status_in = 32'hA700_0000;
    pulseStart();
    pulseRx(8'h07);
    @(negedge clk);
    nTests++;
    if (tx_data !== 8'hA7) begin
      nFail++;
      $display("FAIL ro_read7: tx_data=%h, want a7", tx_data);
    end
    pulseRx(8'h11);
    nTests++;
    if (wr_strobe !== 4'b0000 || regs_out !== 32'd0) begin
      nFail++;
      $display("FAIL ro_drop: strobe=%b regs=%h, want 0000 0", wr_strobe, regs_out);
    end
    pulseRx(8'h22);
    nTests++;
    if (regs_out !== 32'h0000_0022 || wr_strobe !== 4'b0001) begin
      nFail++;
      $display("FAIL ro_wrap: regs=%h strobe=%b, want 00000022 0001", regs_out, wr_strobe);
    end
  endtask

  task automatic test_bad_ptr();
    doReset();
    status_in = 32'h1234_5678;
    pulseStart();
    pulseRx(8'h20);
    pulseRx(8'h99);
    nTests++;
    if (regs_out !== 32'd0 || wr_strobe !== 4'b0000) begin
      nFail++;
      $display("FAIL bad_drop: regs=%h strobe=%b, want 0 0000", regs_out, wr_strobe);
    end
    pulseStart();
    repeat (2) @(negedge clk);
    nTests++;
    if (tx_data !== 8'hFF) begin
      nFail++;
      $display("FAIL bad_read: tx_data=%h, want ff", tx_data);
    end
    // Pointer equal to NREGS is also out of range.
    pulseStart();
    pulseRx(8'h08);
    pulseRx(8'h5A);
    nTests++;
    if (regs_out !== 32'd0 || wr_strobe !== 4'b0000) begin
      nFail++;
      $display("FAIL bad_nregs: regs=%h strobe=%b, want 0 0000", regs_out, wr_strobe);
    end
  endtask

  task automatic test_watchdog();
    doReset();
    pulseStart();
    pulseRx(8'h00);
    pulseRx(8'h80);
    repeat (15) @(negedge clk);
    nTests++;
    if (regs_out[7:0] !== 8'h80 || wdt_expired !== 1'b0) begin
      nFail++;
      $display("FAIL wdt_early: reg0=%h wdt=%b, want 80 0", regs_out[7:0], wdt_expired);
    end
    @(negedge clk);
    nTests++;
    if (regs_out[7:0] !== 8'h00 || wdt_expired !== 1'b1 || wr_strobe !== 4'b0000) begin
      nFail++;
      $display("FAIL wdt_expire: reg0=%h wdt=%b strobe=%b, want 00 1 0000",
               regs_out[7:0], wdt_expired, wr_strobe);
    end
    pulseStart();
    pulseRx(8'h00);
    pulseRx(8'h01);
    nTests++;
    if (regs_out[7:0] !== 8'h01 || wdt_expired !== 1'b0) begin
      nFail++;
      $display("FAIL wdt_rewrite: reg0=%h wdt=%b, want 01 0", regs_out[7:0], wdt_expired);
    end
  endtask

  task automatic test_reset_collisions();
    doReset();
    pulseStart();
    pulseRx(8'h01);
    doReset();
    pulseRx(8'h77);
    nTests++;
    if (regs_out !== 32'd0 || wr_strobe !== 4'b0000) begin
      nFail++;
      $display("FAIL rst_abort: regs=%h strobe=%b, want 0 0000", regs_out, wr_strobe);
    end
    pulseStart();
    pulseRx(8'h00);
    pulseRxTx(8'h42);
    pulseRx(8'h43);
    nTests++;
    if (regs_out !== 32'h0000_4342) begin
      nFail++;
      $display("FAIL rx_tx_collide: regs=%h, want 00004342", regs_out);
    end
    pulseStartStop();
    pulseRx(8'h02);
    pulseRx(8'h66);
    nTests++;
    if (regs_out[23:16] !== 8'h66 || wr_strobe !== 4'b0100) begin
      nFail++;
      $display("FAIL start_stop: reg2=%h strobe=%b, want 66 0100", regs_out[23:16], wr_strobe);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_combined_read();
    test_ro_wrap();
    test_bad_ptr();
    test_watchdog();
    test_reset_collisions();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
